// File: rtl/irq_controller.sv
// Machine-mode external interrupt sequencer: latches request edges, picks the
// lowest enabled pending source, raises a trap and acknowledges it after mret.
module irq_controller #(
    parameter int unsigned N_IRQ = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             exception_i,
    input  logic             mret_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [31:0]      mie_i,
    output logic             irq_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic             busy_o
);

    localparam int unsigned IDX_W = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_TRAP    = 2'd1;
    localparam logic [1:0] S_HANDLER = 2'd2;
    localparam logic [1:0] S_ACK     = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] req_prev_q;

    logic [N_IRQ-1:0] edge_c;
    logic [N_IRQ-1:0] elig_c;
    logic [N_IRQ-1:0] clr_c;
    logic [IDX_W-1:0] sel_c;

    logic             irq_d;
    logic [31:0]      mcause_d;
    logic [N_IRQ-1:0] ack_d;
    logic             busy_d;

    // Enable bits above the implemented source count carry no meaning.
    logic unused_mie;
    assign unused_mie = ^mie_i[31:N_IRQ];

    assign edge_c = irq_req_i & ~req_prev_q;
    assign elig_c = pending_q & mie_i[N_IRQ-1:0];

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        sel_c = '0;
        for (int k = int'(N_IRQ) - 1; k >= 0; k--) begin
            if (elig_c[k]) begin
                sel_c = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            pending_q  <= '0;
            req_prev_q <= '0;
            irq_o      <= 1'b0;
            mcause_o   <= '0;
            irq_ack_o  <= '0;
            busy_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            req_prev_q <= irq_req_i;
            irq_o      <= irq_d;
            mcause_o   <= mcause_d;
            irq_ack_o  <= ack_d;
            busy_o     <= busy_d;
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_c   = '0;

        case (state_q)
            S_IDLE: begin
                if ((|elig_c) && !exception_i) begin
                    idx_d   = sel_c;
                    state_d = S_TRAP;
                end
            end
            S_TRAP: begin
                if (!stall_i) begin
                    state_d = S_HANDLER;
                end
            end
            S_HANDLER: begin
                if (mret_i) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                clr_c   = N_IRQ'(1) << idx_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fresh edge in the clearing cycle keeps the source pending.
        pending_d = (pending_q & ~clr_c) | edge_c;

        irq_d    = (state_d == S_TRAP);
        mcause_d = (state_d == S_TRAP) ? {1'b1, 26'd0, 1'b1, idx_d} : mcause_o;
        ack_d    = (state_d == S_ACK) ? (N_IRQ'(1) << idx_d) : '0;
        busy_d   = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: per-cycle vector table plus an
// asynchronous-reset sequence.
module tb_irq_controller;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        exception_i;
    logic        mret_i;
    logic [15:0] irq_req_i;
    logic [31:0] mie_i;
    logic        irq_o;
    logic [31:0] mcause_o;
    logic [15:0] irq_ack_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    irq_controller #(.N_IRQ(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .exception_i (exception_i),
        .mret_i      (mret_i),
        .irq_req_i   (irq_req_i),
        .mie_i       (mie_i),
        .irq_o       (irq_o),
        .mcause_o    (mcause_o),
        .irq_ack_o   (irq_ack_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        stall;
        logic        exc;
        logic        mret;
        logic [15:0] req;
        logic [31:0] mie;
        logic        irq;
        logic [31:0] mcause;
        logic [15:0] ack;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic ex, logic mr, logic [15:0] rq,
                                logic [31:0] me, logic iq, logic [31:0] mc,
                                logic [15:0] ak, logic bz);
        vec_t v;
        v.stall = st; v.exc = ex; v.mret = mr; v.req = rq; v.mie = me;
        v.irq = iq; v.mcause = mc; v.ack = ak; v.busy = bz;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic iq, input logic [31:0] mc,
                              input logic [15:0] ak, input logic bz);
        check({tag, " irq_o"},     32'(irq_o),     32'(iq));
        check({tag, " mcause_o"},  mcause_o,       mc);
        check({tag, " irq_ack_o"}, 32'(irq_ack_o), 32'(ak));
        check({tag, " busy_o"},    32'(busy_o),    32'(bz));
    endtask

    // Drive one cycle of inputs, clock, then sample just after the edge.
    task automatic step(input vec_t v, input string tag);
        stall_i     = v.stall;
        exception_i = v.exc;
        mret_i      = v.mret;
        irq_req_i   = v.req;
        mie_i       = v.mie;
        @(posedge clk_i);
        #1;
        check_outs(tag, v.irq, v.mcause, v.ack, v.busy);
    endtask

    localparam logic [31:0] C11 = 32'h8000_0011;
    localparam logic [31:0] C12 = 32'h8000_0012;
    localparam logic [31:0] C13 = 32'h8000_0013;
    localparam logic [31:0] C15 = 32'h8000_0015;
    localparam logic [31:0] C17 = 32'h8000_0017;

    initial begin
        // single source 3: latency, one-cycle irq, ack after mret
        vecs.push_back(mk(0,0,0,16'h0008,32'h0008, 0,32'h0,  16'h0000,0));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0008, 1,C13,    16'h0000,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0008, 0,C13,    16'h0000,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0008, 0,C13,    16'h0000,1));
        vecs.push_back(mk(0,0,1,16'h0000,32'h0008, 0,C13,    16'h0008,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0008, 0,C13,    16'h0000,0));
        // masked source 5 stays pending until enabled
        vecs.push_back(mk(0,0,0,16'h0020,32'h0000, 0,C13,    16'h0000,0));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0000, 0,C13,    16'h0000,0));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0020, 1,C15,    16'h0000,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0020, 0,C15,    16'h0000,1));
        vecs.push_back(mk(0,0,1,16'h0000,32'h0020, 0,C15,    16'h0020,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0020, 0,C15,    16'h0000,0));
        // simultaneous 2 and 7: served in ascending order
        vecs.push_back(mk(0,0,0,16'h0084,32'h0084, 0,C15,    16'h0000,0));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0084, 1,C12,    16'h0000,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0084, 0,C12,    16'h0000,1));
        vecs.push_back(mk(0,0,1,16'h0000,32'h0084, 0,C12,    16'h0004,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0084, 0,C12,    16'h0000,0));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0084, 1,C17,    16'h0000,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0084, 0,C17,    16'h0000,1));
        vecs.push_back(mk(0,0,1,16'h0000,32'h0084, 0,C17,    16'h0080,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0084, 0,C17,    16'h0000,0));
        // stall holds TRAP; mie/req changes in TRAP do not move idx
        vecs.push_back(mk(0,0,0,16'h0008,32'h0008, 0,C17,    16'h0000,0));
        vecs.push_back(mk(1,0,0,16'h0000,32'h0008, 1,C13,    16'h0000,1));
        vecs.push_back(mk(1,0,0,16'h0000,32'h0008, 1,C13,    16'h0000,1));
        vecs.push_back(mk(1,0,0,16'h0001,32'h0001, 1,C13,    16'h0000,1));
        vecs.push_back(mk(1,0,0,16'h0000,32'h0001, 1,C13,    16'h0000,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0008, 0,C13,    16'h0000,1));
        vecs.push_back(mk(0,0,1,16'h0000,32'h0008, 0,C13,    16'h0008,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0008, 0,C13,    16'h0000,0));
        // exception defers trap; re-edge on ack cycle retriggers
        vecs.push_back(mk(0,0,0,16'h0002,32'h0002, 0,C13,    16'h0000,0));
        vecs.push_back(mk(0,1,0,16'h0002,32'h0002, 0,C13,    16'h0000,0));
        vecs.push_back(mk(0,1,0,16'h0002,32'h0002, 0,C13,    16'h0000,0));
        vecs.push_back(mk(0,0,0,16'h0002,32'h0002, 1,C11,    16'h0000,1));
        vecs.push_back(mk(0,0,0,16'h0002,32'h0002, 0,C11,    16'h0000,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0002, 0,C11,    16'h0000,1));
        vecs.push_back(mk(0,0,1,16'h0000,32'h0002, 0,C11,    16'h0002,1));
        vecs.push_back(mk(0,0,0,16'h0002,32'h0002, 0,C11,    16'h0000,0));
        vecs.push_back(mk(0,0,0,16'h0002,32'h0002, 1,C11,    16'h0000,1));
        vecs.push_back(mk(0,0,0,16'h0000,32'h0002, 0,C11,    16'h0000,1));
        vecs.push_back(mk(0,0,1,16'h0000,32'h0002, 0,C11,    16'h0002,1));
        vecs.push_back(mk(0,0,1,16'h0000,32'h0002, 0,C11,    16'h0000,0));
        vecs.push_back(mk(0,0,1,16'h0000,32'h0002, 0,C11,    16'h0000,0));

        rst_i       = 1'b0;
        stall_i     = 1'b0;
        exception_i = 1'b0;
        mret_i      = 1'b0;
        irq_req_i   = '0;
        mie_i       = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_outs("reset", 1'b0, 32'h0, 16'h0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // async reset while in HANDLER, request line held high across it
        step(mk(0,0,0,16'h0008,32'h0008, 0,C11,16'h0000,0), "rs0");
        step(mk(0,0,0,16'h0008,32'h0008, 1,C13,16'h0000,1), "rs1");
        step(mk(0,0,0,16'h0008,32'h0008, 0,C13,16'h0000,1), "rs2");
        #2;
        rst_i = 1'b0;
        #1;
        check_outs("rst_async", 1'b0, 32'h0, 16'h0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step(mk(0,0,0,16'h0008,32'h0008, 0,32'h0,16'h0000,0), "rel0");
        step(mk(0,0,0,16'h0008,32'h0008, 1,C13,  16'h0000,1), "rel1");
        step(mk(0,0,0,16'h0008,32'h0008, 0,C13,  16'h0000,1), "rel2");
        step(mk(0,0,1,16'h0008,32'h0008, 0,C13,  16'h0008,1), "rel3");
        step(mk(0,0,0,16'h0008,32'h0008, 0,C13,  16'h0000,0), "rel4");
        for (int i = 0; i < 3; i++) begin
            step(mk(0,0,0,16'h0008,32'h0008, 0,C13,16'h0000,0), $sformatf("hold%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Sequences the machine-mode trap path for external interrupts.
- Latches up to N_IRQ interrupt request lines, masks them with the mie register, and picks one source by fixed priority.
- Raises a trap request toward the CSR controller and core, supplying mepc/mcause write strobe and cause code.
- Holds off further traps until mret, then acknowledges the served source.
- Sits between the peripheral interrupt lines and the CSR controller / core control unit.

Parameters:
N_IRQ, 16, number of interrupt sources (1..16); source k maps to mcause code 16+k

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
stall_i  input  1  core stalled; a trap must not complete while high
exception_i  input  1  synchronous exception this cycle; blocks starting a new interrupt trap
mret_i  input  1  mret executed, one-cycle pulse
irq_req_i  input  N_IRQ  level interrupt request lines, synchronous to clk_i
mie_i  input  32  mie CSR value; bit k enables source k (bits >= N_IRQ ignored)
irq_o  input→output  1  trap request to core/CSR (drives trap_i)
mcause_o  output  32  cause for the current/last interrupt trap
irq_ack_o  output  N_IRQ  one-hot acknowledge of the served source, one-cycle pulse
busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_i low, async):
  - state=IDLE; pending_q, req_prev_q, idx_q cleared.
  - irq_o=0, irq_ack_o=0, mcause_o=0, busy_o=0.
  - Reset mid-operation abandons the trap with no ack.
- Edge detection:
  - req_prev_q[k] <= irq_req_i[k] every cycle.
  - Rising edge (req & ~prev) sets pending_q[k].
  - req_prev_q resets to 0, so a line already high at reset release registers as an edge in the first cycle.
- Pending latch:
  - Masked sources still latch pending; they are only excluded from selection.
  - pending_q[k] clears only in ACK for k == idx_q.
  - A new edge on k in the same cycle as its clear: set wins (pending stays 1).
- Eligibility: elig = pending_q & mie_i[N_IRQ-1:0]. Selection is the lowest set index of elig.
- FSM states: IDLE, TRAP, HANDLER, ACK.
  - IDLE:
    - If elig != 0 and exception_i == 0: idx_q <= selected index, go to TRAP.
    - exception_i high defers the trap by one cycle per asserted cycle.
    - stall_i does not block the IDLE->TRAP step.
    - mret_i is ignored.
  - TRAP:
    - irq_o=1 (registered state decode, no combinational path from irq_req_i).
    - mcause_o = 32'h8000_0010 + idx_q, valid throughout TRAP.
    - If stall_i is high: stay in TRAP, irq_o stays high, idx_q and mcause_o stay frozen.
    - If stall_i is low: go to HANDLER.
    - Minimum irq_o width is 1 cycle; latency from the pending edge to irq_o is 2 cycles (edge registered, then TRAP).
    - Changes to mie_i or irq_req_i during TRAP do not alter idx_q.
  - HANDLER:
    - irq_o=0. Wait for mret_i=1, then go to ACK.
    - Other pending sources accumulate and are not served (no nesting).
  - ACK:
    - irq_ack_o[idx_q]=1 for exactly one cycle; clear pending_q[idx_q]; go to IDLE.
    - The next trap can be requested in the following IDLE cycle.
- mcause_o keeps its last value after TRAP until the next TRAP loads a new idx_q.
- Arithmetic: idx_q is 4 bits. The cause code is zero-extended into bits [4:0]; bit 31 = 1 (interrupt).
- Simultaneous edges on several sources: all latch; they are served in ascending index order, one per FSM round.
- mret_i outside HANDLER has no effect. A second mret_i in ACK is ignored.

Test Plan:
- N_IRQ=16, mie_i=32'h0000_0008; pulse irq_req_i[3] for 1 cycle -> irq_o high exactly 1 cycle 2 cycles later, mcause_o=32'h8000_0013; mret_i -> irq_ack_o=16'h0008 for 1 cycle the next cycle, busy_o returns to 0.
- mie_i=0; edge on irq_req_i[5] -> no irq_o. Later set mie_i[5]=1 -> trap with mcause_o=32'h8000_0015 (pending retained while masked).
- Simultaneous edges on sources 2 and 7, both enabled -> first trap mcause 0x8000_0012; after mret/ack, second trap 0x8000_0017, no extra edge needed.
- Enter TRAP with stall_i held high 3 cycles -> irq_o high 4 cycles, mcause_o stable; no HANDLER entry until stall_i low.
- exception_i high in the IDLE cycle where a source is eligible -> TRAP delayed until the first cycle exception_i=0. Separately, the source re-edges during HANDLER -> after ACK it traps again.
- Assert rst_i low while in HANDLER -> irq_o, irq_ack_o, mcause_o, busy_o immediately 0. After release, a line held high traps once.
